boton_eventos: RTL and testbench

Button event decoder for the 12 MHz user-interface path. It consumes the already debounced, clock-synchronous level from the push-button debouncer and turns it into single-cycle event pulses: press, release, short press, long press and auto-repeat while held. Downstream FSMs use these pulses instead of edge-detecting the button level themselves.

---
 rtl/boton_eventos.sv | 97 +++++++++
 tb/tb_boton_eventos.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/boton_eventos.sv
// rtl/boton_eventos.sv - button event decoder: press, release, short, long and auto-repeat pulses
// Consumes a debounced, clk-synchronous button level; all outputs are registered.
module boton_eventos #(
  parameter int unsigned LONG_CYCLES   = 12000000,
  parameter int unsigned REPEAT_CYCLES = 2400000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_clean,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [23:0] LONG_LAST   = 24'(LONG_CYCLES - 1);
  localparam logic [23:0] REPEAT_LAST = 24'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    PRESSED,
    LONG
  } state_t;

  state_t      state;
  logic [23:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARM;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        // A button already down when reset lifts must be released before it counts.
        ARM: begin
          held <= 1'b0;
          if (!btn_clean) state <= IDLE;
        end
        IDLE: begin
          held <= 1'b0;
          if (btn_clean) begin
            press_pulse <= 1'b1;
            cnt         <= '0;
            held        <= 1'b1;
            state       <= PRESSED;
          end
        end
        PRESSED: begin
          if (!btn_clean) begin
            release_pulse <= 1'b1;
            short_pulse   <= 1'b1;
            held          <= 1'b0;
            state         <= IDLE;
          end else if (cnt == LONG_LAST) begin
            long_pulse <= 1'b1;
            cnt        <= '0;
            state      <= LONG;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        LONG: begin
          // Release is checked first so it always wins over a coincident repeat.
          if (!btn_clean) begin
            release_pulse <= 1'b1;
            held          <= 1'b0;
            state         <= IDLE;
          end else if (cnt == REPEAT_LAST) begin
            repeat_pulse <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end
        default: begin
          held  <= 1'b0;
          state <= ARM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boton_eventos.sv
// tb/tb_boton_eventos.sv - directed bench for boton_eventos
// Observed vector order: {press, release, short, long, repeat, held}.
module tb_boton_eventos;

  localparam logic [5:0] E_NONE  = 6'b000000;
  localparam logic [5:0] E_HELD  = 6'b000001;
  localparam logic [5:0] E_PRESS = 6'b100001;
  localparam logic [5:0] E_RELSH = 6'b011000;
  localparam logic [5:0] E_REL   = 6'b010000;
  localparam logic [5:0] E_LONG  = 6'b000101;
  localparam logic [5:0] E_REP   = 6'b000011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_clean = 1'b0;
  logic press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;
  logic [5:0] obs;

  int tests = 0;
  int fails = 0;

  assign obs = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held};

  boton_eventos #(
    .LONG_CYCLES  (10),
    .REPEAT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_clean    (btn_clean),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .held         (held)
  );

  always #5 clk = ~clk;

  // Drive the level, let one rising edge sample it, then settle before looking.
  task automatic cyc(input logic b);
    btn_clean = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_and_short;
    rst = 1'b1;
    cyc(1'b0);
    tests++;
    if (obs !== E_NONE) begin
      fails++;
      $display("FAIL reset_state: got %b expected %b", obs, E_NONE);
    end
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cyc(1'b0);
      tests++;
      if (obs !== E_NONE) begin
        fails++;
        $display("FAIL idle_low cycle %0d: got %b expected %b", j, obs, E_NONE);
      end
    end
    for (int j = 0; j < 5; j++) begin
      logic [5:0] exp;
      cyc(j < 3 ? 1'b1 : 1'b0);
      exp = (j == 0) ? E_PRESS : (j < 3) ? E_HELD : (j == 3) ? E_RELSH : E_NONE;
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL short_press cycle %0d: got %b expected %b", j, obs, exp);
      end
    end
  endtask

  task automatic test_long_repeat;
    for (int j = 0; j <= 26; j++) begin
      logic [5:0] exp;
      cyc(j < 25 ? 1'b1 : 1'b0);
      if (j == 0) exp = E_PRESS;
      else if (j == 10) exp = E_LONG;
      else if (j > 10 && j < 25 && ((j - 10) % 4) == 0) exp = E_REP;
      else if (j < 25) exp = E_HELD;
      else if (j == 25) exp = E_REL;
      else exp = E_NONE;
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL long_repeat edge +%0d: got %b expected %b", j, obs, exp);
      end
    end
  endtask

  task automatic test_release_at_threshold;
    for (int j = 0; j <= 11; j++) begin
      logic [5:0] exp;
      cyc(j <= 9 ? 1'b1 : 1'b0);
      exp = (j == 0) ? E_PRESS : (j <= 9) ? E_HELD : (j == 10) ? E_RELSH : E_NONE;
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL release_at_long edge +%0d: got %b expected %b", j, obs, exp);
      end
    end
  endtask

  task automatic test_held_through_reset;
    rst = 1'b1;
    cyc(1'b1);
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      cyc(1'b1);
      tests++;
      if (obs !== E_NONE) begin
        fails++;
        $display("FAIL arm_hold cycle %0d: got %b expected %b", j, obs, E_NONE);
      end
    end
    cyc(1'b0);
    tests++;
    if (obs !== E_NONE) begin
      fails++;
      $display("FAIL arm_release: got %b expected %b", obs, E_NONE);
    end
    cyc(1'b1);
    tests++;
    if (obs !== E_PRESS) begin
      fails++;
      $display("FAIL arm_repress: got %b expected %b", obs, E_PRESS);
    end
    cyc(1'b0);
    tests++;
    if (obs !== E_RELSH) begin
      fails++;
      $display("FAIL arm_rerelease: got %b expected %b", obs, E_RELSH);
    end
  endtask

  task automatic test_reset_mid_press;
    for (int j = 0; j < 12; j++) begin
      logic [5:0] exp;
      cyc(1'b1);
      exp = (j == 0) ? E_PRESS : (j == 10) ? E_LONG : E_HELD;
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL pre_abort edge +%0d: got %b expected %b", j, obs, exp);
      end
    end
    rst = 1'b1;
    cyc(1'b1);
    tests++;
    if (obs !== E_NONE) begin
      fails++;
      $display("FAIL abort_reset: got %b expected %b", obs, E_NONE);
    end
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      cyc(j < 5 ? 1'b1 : 1'b0);
      tests++;
      if (obs !== E_NONE) begin
        fails++;
        $display("FAIL abort_silent cycle %0d: got %b expected %b", j, obs, E_NONE);
      end
    end
    cyc(1'b1);
    tests++;
    if (obs !== E_PRESS) begin
      fails++;
      $display("FAIL abort_repress: got %b expected %b", obs, E_PRESS);
    end
    cyc(1'b0);
    tests++;
    if (obs !== E_RELSH) begin
      fails++;
      $display("FAIL abort_rerelease: got %b expected %b", obs, E_RELSH);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] pat;
    logic [5:0] exp;
    logic [4:0] p;
    pat = 4'b0101;
    for (int j = 0; j < 5; j++) begin
      cyc(j < 4 ? pat[j] : 1'b0);
      exp = (j == 4) ? E_NONE : (j % 2 == 0) ? E_PRESS : E_RELSH;
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", j, obs, exp);
      end
      p = obs[5:1];
      tests++;
      if (!($countones(p) <= 1 || p == 5'b01100)) begin
        fails++;
        $display("FAIL one_hot cycle %0d: got %b expected one-hot or release+short", j, p);
      end
    end
  endtask

  initial begin
    test_reset_and_short();
    test_long_repeat();
    test_release_at_threshold();
    test_held_through_reset();
    test_reset_mid_press();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
